// File: rtl/servo_slew_pkg.sv
// Shared constants for the servo slew limiter: register offsets,
// STATUS bit positions and the STEP register width.
package servo_slew_pkg;

  localparam int STEP_W = 16;

  // Register offsets as decoded from PADDR[3:2]
  localparam logic [1:0] ADDR_XTGT = 2'd0;
  localparam logic [1:0] ADDR_YTGT = 2'd1;
  localparam logic [1:0] ADDR_STEP = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;

  // STATUS read bits
  localparam int STAT_X_SETTLED = 0;
  localparam int STAT_Y_SETTLED = 1;
  localparam int STAT_PARITY    = 2;

  // STATUS write bits
  localparam int STAT_SNAP    = 0;
  localparam int STAT_IRQ_CLR = 1;

endpackage

// File: rtl/servo_slew_limiter_if.sv
// APB3 bus bundle for the servo slew limiter.
// Handshake: zero wait state; a transfer commits in the access phase
// (PSEL & PENABLE), PREADY is always 1, PSLVERR and PRDATA are only
// meaningful while PSEL is high.
interface servo_slew_limiter_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] PRDATA;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PSLVERR, PRDATA
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PSLVERR, PRDATA
  );
endinterface

// File: rtl/servo_slew_limiter_axis.sv
// One servo axis: moves the current pulse width toward the target by at
// most step clocks per frame tick, or jumps straight to it on snap.
module slew_axis
  import servo_slew_pkg::*;
#(
  parameter int               POS_W  = 21,
  parameter logic [POS_W-1:0] CENTER = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [POS_W-1:0]  tgt,
  input  logic [STEP_W-1:0] step,
  input  logic              tick,
  input  logic              snap,
  output logic [POS_W-1:0]  cur,
  output logic              settled
);

  logic signed [POS_W:0] diff;
  logic        [POS_W:0] mag;
  logic        [POS_W:0] step_ext;
  logic [POS_W-1:0]      next_cur;

  // Signed distance to target and the rate-limited next position
  always_comb begin
    diff     = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag      = diff[POS_W] ? -diff : diff;
    step_ext = {{(POS_W + 1 - STEP_W){1'b0}}, step};
    if (mag <= step_ext) begin
      next_cur = tgt;
    end else if (diff[POS_W]) begin
      next_cur = cur - step_ext[POS_W-1:0];
    end else begin
      next_cur = cur + step_ext[POS_W-1:0];
    end
  end

  // Position register: snap has priority over the frame update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= CENTER;
    end else if (snap) begin
      cur <= tgt;
    end else if (tick) begin
      cur <= next_cur;
    end
  end

  assign settled = (cur == tgt);

endmodule

// File: rtl/servo_slew_limiter.sv
// Servo slew limiter: APB3 slave holding X/Y targets and STEP; once per
// frame each axis moves toward its target by at most STEP clocks and a
// one-cycle pulse_vld strobe announces the new widths.
// Optional settle interrupt is enabled by defining SERVO_SLEW_IRQ_EN.
module servo_slew_limiter
  import servo_slew_pkg::*;
#(
  parameter int PWM_PERIOD = 2000000,
  parameter int POS_W      = 21,
  parameter int POS_MIN    = 100000,
  parameter int POS_MAX    = 200000,
  parameter int STEP_RST   = 1000
) (
  input  logic                PCLK,
  input  logic                PRESET,
  servo_slew_limiter_if.slave apb,
  output logic [POS_W-1:0]    x_pulse,
  output logic [POS_W-1:0]    y_pulse,
  output logic                pulse_vld,
  output logic                irq
);

  localparam int               CNT_W  = $clog2(PWM_PERIOD);
  localparam logic [POS_W-1:0] CENTER = POS_W'((POS_MIN + POS_MAX) / 2);

  logic [1:0]        reg_sel;
  logic              wr_en;
  logic              tgt_wr;
  logic              out_of_range;
  logic [POS_W-1:0]  tgt_data;
  logic              snap;
  logic              tick;
  logic [CNT_W-1:0]  count;
  logic              parity;
  logic [POS_W-1:0]  x_tgt;
  logic [POS_W-1:0]  y_tgt;
  logic [STEP_W-1:0] step;
  logic              x_settled;
  logic              y_settled;
  logic [31:0]       rd_data;
  logic              unused_addr;

  assign reg_sel      = apb.PADDR[3:2];
  assign unused_addr  = ^{apb.PADDR[31:4], apb.PADDR[1:0]};
  assign wr_en        = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign tgt_wr       = wr_en & ((reg_sel == ADDR_XTGT) | (reg_sel == ADDR_YTGT));
  assign out_of_range = (apb.PWDATA < 32'(POS_MIN)) || (apb.PWDATA > 32'(POS_MAX));
  assign snap         = wr_en & (reg_sel == ADDR_STAT) & apb.PWDATA[STAT_SNAP];
  assign tick         = (count == CNT_W'(PWM_PERIOD - 1));

  assign apb.PREADY   = 1'b1;
  assign apb.PSLVERR  = tgt_wr & out_of_range;

  // Clamp incoming target writes into the legal pulse range
  always_comb begin
    if (apb.PWDATA < 32'(POS_MIN)) begin
      tgt_data = POS_W'(POS_MIN);
    end else if (apb.PWDATA > 32'(POS_MAX)) begin
      tgt_data = POS_W'(POS_MAX);
    end else begin
      tgt_data = apb.PWDATA[POS_W-1:0];
    end
  end

  // Software-visible configuration registers
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      x_tgt <= CENTER;
      y_tgt <= CENTER;
      step  <= STEP_W'(STEP_RST);
    end else if (wr_en) begin
      case (reg_sel)
        ADDR_XTGT: x_tgt <= tgt_data;
        ADDR_YTGT: y_tgt <= tgt_data;
        ADDR_STEP: step  <= apb.PWDATA[STEP_W-1:0];
        default:   ;
      endcase
    end
  end

  // Free-running frame counter plus a parity bit that flips every frame
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      count  <= '0;
      parity <= 1'b0;
    end else if (tick) begin
      count  <= '0;
      parity <= ~parity;
    end else begin
      count  <= count + CNT_W'(1);
    end
  end

  // Update strobe; a snap coinciding with a tick yields one strobe, and a
  // request landing right after a strobe is folded into that strobe
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      pulse_vld <= 1'b0;
    end else begin
      pulse_vld <= (tick | snap) & ~pulse_vld;
    end
  end

  slew_axis #(.POS_W(POS_W), .CENTER(CENTER)) u_x_axis (
    .clk     (PCLK),
    .rst     (PRESET),
    .tgt     (x_tgt),
    .step    (step),
    .tick    (tick),
    .snap    (snap),
    .cur     (x_pulse),
    .settled (x_settled)
  );

  slew_axis #(.POS_W(POS_W), .CENTER(CENTER)) u_y_axis (
    .clk     (PCLK),
    .rst     (PRESET),
    .tgt     (y_tgt),
    .step    (step),
    .tick    (tick),
    .snap    (snap),
    .cur     (y_pulse),
    .settled (y_settled)
  );

  // Read mux, driven only during a selected read so the bus idles at 0
  always_comb begin
    rd_data = '0;
    if (apb.PSEL && !apb.PWRITE) begin
      case (reg_sel)
        ADDR_XTGT: rd_data = 32'(x_tgt);
        ADDR_YTGT: rd_data = 32'(y_tgt);
        ADDR_STEP: rd_data = 32'(step);
        default: begin
          rd_data[STAT_X_SETTLED] = x_settled;
          rd_data[STAT_Y_SETTLED] = y_settled;
          rd_data[STAT_PARITY]    = parity;
        end
      endcase
    end
  end

  assign apb.PRDATA = rd_data;

`ifdef SERVO_SLEW_IRQ_EN
  logic all_settled;
  logic settled_q;
  logic moved_q;
  logic irq_set;
  logic irq_clr;

  assign all_settled = x_settled & y_settled;
  assign irq_set     = all_settled & ~settled_q & moved_q;
  assign irq_clr     = wr_en & (reg_sel == ADDR_STAT) & apb.PWDATA[STAT_IRQ_CLR];

  // Settle interrupt: fires when both axes become settled after real motion
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      settled_q <= 1'b1;
      moved_q   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      settled_q <= all_settled;
      if (irq_set) begin
        moved_q <= 1'b0;
      end else if (tick && !snap && !all_settled && (step != '0)) begin
        moved_q <= 1'b1;
      end
      irq <= irq_set | (irq & ~irq_clr);
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_servo_slew_limiter.sv
// Directed bench for servo_slew_limiter with PWM_PERIOD=100. Stimulus
// pushes the expected {x_pulse,y_pulse} for each upcoming strobe; the
// monitor pops and compares whenever pulse_vld is seen.
module tb_servo_slew_limiter;
  import servo_slew_pkg::*;

  localparam int               POS_W = 21;
  localparam logic [POS_W-1:0] C     = 21'd150000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  servo_slew_limiter_if apb();
  logic [POS_W-1:0] x_pulse;
  logic [POS_W-1:0] y_pulse;
  logic             pulse_vld;
  logic             irq;

  servo_slew_limiter #(
    .PWM_PERIOD (100),
    .POS_W      (POS_W),
    .POS_MIN    (100000),
    .POS_MAX    (200000),
    .STEP_RST   (1000)
  ) dut (
    .PCLK      (clk),
    .PRESET    (rst),
    .apb       (apb),
    .x_pulse   (x_pulse),
    .y_pulse   (y_pulse),
    .pulse_vld (pulse_vld),
    .irq       (irq)
  );

  int checks      = 0;
  int failures    = 0;
  int cyc         = 0;
  int last_strobe = 0;
  logic [2*POS_W-1:0] exp_q[$];
  logic [2*POS_W-1:0] exp_e;
  logic               prev_vld;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expectation
  always @(negedge clk) begin
    if (rst) begin
      prev_vld <= 1'b0;
    end else begin
      if (pulse_vld) begin
        check("strobe_not_back_to_back", 32'(prev_vld), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: got strobe at cycle %0d expected none", cyc);
        end else begin
          exp_e = exp_q.pop_front();
          check("x_pulse", 32'(x_pulse), 32'(exp_e[2*POS_W-1:POS_W]));
          check("y_pulse", 32'(y_pulse), 32'(exp_e[POS_W-1:0]));
        end
`ifndef SERVO_SLEW_IRQ_EN
        check("irq_disabled", 32'(irq), 32'd0);
`endif
      end
      prev_vld <= pulse_vld;
    end
  end

  task automatic apb_write(input logic [1:0] addr, input logic [31:0] data, input logic exp_err);
    @(posedge clk); #1;
    apb.PSEL    = 1'b1;
    apb.PWRITE  = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PADDR   = {28'd0, addr, 2'b00};
    apb.PWDATA  = data;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    #1;
    check("pslverr", 32'(apb.PSLVERR), 32'(exp_err));
    @(posedge clk); #1;
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
  endtask

  task automatic apb_read(input logic [1:0] addr, output logic [31:0] data);
    @(posedge clk); #1;
    apb.PSEL    = 1'b1;
    apb.PWRITE  = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PADDR   = {28'd0, addr, 2'b00};
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    #1;
    data = apb.PRDATA;
    @(posedge clk); #1;
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!pulse_vld && n < 400);
    if (!pulse_vld) begin
      checks++;
      failures++;
      $display("FAIL strobe_timeout: got no strobe in %0d cycles expected one", n);
    end
    last_strobe = cyc;
  endtask

  task automatic frame(input logic [POS_W-1:0] x, input logic [POS_W-1:0] y);
    int n;
    exp_q.push_back({x, y});
    wait_strobe(n);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] rd;
    int n;
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
    apb.PADDR   = '0;
    apb.PWDATA  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_x_pulse", 32'(x_pulse), 32'd150000);
    check("rst_y_pulse", 32'(y_pulse), 32'd150000);
    check("rst_pulse_vld", 32'(pulse_vld), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_pslverr", 32'(apb.PSLVERR), 32'd0);
    check("rst_prdata", apb.PRDATA, 32'd0);
    check("pready", 32'(apb.PREADY), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back({C, C});
    wait_strobe(n);
    check("first_tick_latency", 32'(n), 32'd100);
    apb_read(ADDR_STEP, rd); check("step_reset", rd, 32'd1000);
    apb_read(ADDR_STAT, rd); check("status_reset", rd & 32'h3, 32'h3);
    apb_read(ADDR_XTGT, rd); check("xtgt_reset", rd, 32'd150000);
    apb_read(ADDR_YTGT, rd); check("ytgt_reset", rd, 32'd150000);

    // Slew X up by 5000 in 1000 steps
    apb_write(ADDR_XTGT, 32'd155000, 1'b0);
    apb_read(ADDR_STAT, rd); check("x_unsettled", rd & 32'h3, 32'h2);
    for (int i = 1; i <= 5; i++) begin
      frame(C + POS_W'(1000 * i), C);
      apb_read(ADDR_STAT, rd);
      check("x_settle_progress", rd & 32'h3, (i == 5) ? 32'h3 : 32'h2);
    end

    // Target clamping, boundaries and STEP width
    apb_write(ADDR_YTGT, 32'd250000, 1'b1);
    apb_read(ADDR_YTGT, rd); check("ytgt_clamp_hi", rd, 32'd200000);
    apb_write(ADDR_YTGT, 32'd50000, 1'b1);
    apb_read(ADDR_YTGT, rd); check("ytgt_clamp_lo", rd, 32'd100000);
    apb_write(ADDR_YTGT, 32'd200000, 1'b0);
    apb_read(ADDR_YTGT, rd); check("ytgt_max_exact", rd, 32'd200000);
    apb_write(ADDR_YTGT, 32'd150000, 1'b0);
    apb_write(ADDR_STEP, 32'h0001_03E8, 1'b0);
    apb_read(ADDR_STEP, rd); check("step_width", rd, 32'd1000);
    frame(21'd155000, C);

    // SNAP back to center, then a sub-step move that must not overshoot
    apb_write(ADDR_XTGT, 32'd150000, 1'b0);
    exp_q.push_back({C, C});
    apb_write(ADDR_STAT, 32'h1, 1'b0);
    apb_write(ADDR_STEP, 32'd3000, 1'b0);
    apb_write(ADDR_XTGT, 32'd151000, 1'b0);
    frame(21'd151000, C);
    apb_read(ADDR_STAT, rd); check("no_overshoot_settled", rd & 32'h3, 32'h3);

    // STEP=0 freezes motion but still strobes
    apb_write(ADDR_STEP, 32'd0, 1'b0);
    apb_write(ADDR_XTGT, 32'd160000, 1'b0);
    for (int i = 0; i < 3; i++) frame(21'd151000, C);
    apb_write(ADDR_STEP, 32'd1000, 1'b0);
    frame(21'd152000, C);

    // Target write committing on the tick edge uses the old target
    exp_q.push_back({21'd153000, C});
    wait_to(last_strobe + 97);
    apb_write(ADDR_XTGT, 32'd152500, 1'b0);
    last_strobe = cyc;
    frame(21'd152500, C);
    apb_read(ADDR_XTGT, rd); check("xtgt_tick_write", rd, 32'd152500);

    // SNAP on the tick edge wins and leaves the frame timing alone
    apb_write(ADDR_XTGT, 32'd150000, 1'b0);
    exp_q.push_back({C, C});
    wait_to(last_strobe + 97);
    apb_write(ADDR_STAT, 32'h1, 1'b0);
    exp_q.push_back({C, C});
    wait_strobe(n);
    check("frame_after_tick_snap", 32'(n), 32'd100);

    // Settle interrupt around a two-frame move
`ifdef SERVO_SLEW_IRQ_EN
    apb_write(ADDR_STAT, 32'h2, 1'b0);
    check("irq_pre_clear", 32'(irq), 32'd0);
`endif
    apb_write(ADDR_XTGT, 32'd152000, 1'b0);
    frame(21'd151000, C);
    check("irq_after_strobe1", 32'(irq), 32'd0);
    frame(21'd152000, C);
    check("irq_on_strobe2", 32'(irq), 32'd0);
    @(posedge clk); #1;
`ifdef SERVO_SLEW_IRQ_EN
    check("irq_set", 32'(irq), 32'd1);
    apb_write(ADDR_STAT, 32'h2, 1'b0);
    check("irq_cleared", 32'(irq), 32'd0);
`else
    check("irq_stays_low", 32'(irq), 32'd0);
`endif

    // Reset in mid-frame
    wait_to(last_strobe + 40);
    rst = 1'b1;
    #1;
    check("midrst_x_pulse", 32'(x_pulse), 32'd150000);
    check("midrst_pulse_vld", 32'(pulse_vld), 32'd0);
    check("midrst_irq", 32'(irq), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back({C, C});
    wait_strobe(n);
    check("midrst_tick_latency", 32'(n), 32'd100);
    apb_read(ADDR_XTGT, rd); check("midrst_xtgt", rd, 32'd150000);
    apb_read(ADDR_STEP, rd); check("midrst_step", rd, 32'd1000);

    @(negedge clk);
    @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/servo_slew_limiter.md
Name: servo_slew_limiter

Overview:
- APB3 slave on CoreAPB3 slot 2, clocked from the MSS fabric clock.
- Sits directly upstream of the servo PWM stage. Software writes X/Y target pulse widths.
- Once per servo frame, the block moves each axis's current pulse width toward its target by at most STEP clocks.
- Presents the rate-limited widths plus a one-cycle update strobe to the PWM generator. This gives smooth pan/tilt motion from coarse controller input.

Parameters:
- PWM_PERIOD, 2000000, clocks per servo frame.
- POS_W, 21, pulse-width word width; must hold PWM_PERIOD-1.
- POS_MIN, 100000, minimum legal pulse width in clocks.
- POS_MAX, 200000, maximum legal pulse width in clocks.
- STEP_RST, 1000, reset value of the STEP register.

Ports:
- PCLK  in  1  fabric clock (single clock domain).
- PRESET  in  1  reset, asynchronous, active-high.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  APB write.
- PADDR  in  32  APB address; only [3:2] decoded.
- PWDATA  in  32  APB write data.
- PREADY  out  1  always 1.
- PSLVERR  out  1  out-of-range target write error.
- PRDATA  out  32  APB read data.
- x_pulse  out  POS_W  current X pulse width to PWM stage.
- y_pulse  out  POS_W  current Y pulse width to PWM stage.
- pulse_vld  out  1  one-cycle strobe when x_pulse/y_pulse are updated.
- irq  out  1  settle interrupt; see Optional Feature.

Behaviour:
- Reset (async, while PRESET=1):
  - X_TGT = Y_TGT = x_pulse = y_pulse = CENTER = (POS_MIN+POS_MAX)/2.
  - STEP = STEP_RST; frame counter = 0.
  - pulse_vld = 0, PSLVERR = 0, irq = 0, PRDATA = 0.
- Register map (PADDR[3:2]):
  - 0 X_TGT, RW, bits [POS_W-1:0].
  - 1 Y_TGT, RW, bits [POS_W-1:0].
  - 2 STEP, RW, bits [15:0].
  - 3 STATUS. Read: bit0 x_settled (x_pulse==X_TGT), bit1 y_settled, bit2 frame_parity (toggles each frame). Write: bit0 SNAP, which copies targets into current immediately and strobes pulse_vld the next cycle.
- APB access:
  - Zero wait state. A write commits when PSEL & PENABLE & PWRITE.
  - PRDATA is combinational from PADDR; unused bits read 0.
- Target write clamping:
  - A target write with value < POS_MIN or > POS_MAX stores the clamped value.
  - PSLVERR=1 during that access phase only; 0 otherwise.
  - STEP writes are never in error.
- Frame counter:
  - Runs 0..PWM_PERIOD-1 and wraps.
  - tick = (count == PWM_PERIOD-1).
- On tick, per axis:
  - diff = tgt - cur, computed at POS_W+1 signed width.
  - If |diff| <= STEP, cur <= tgt; else cur <= cur ± STEP.
  - pulse_vld = 1 on the cycle after tick (registered), with the updated values visible that cycle.
  - STEP = 0 freezes motion (pulse_vld still strobes).
- Simultaneous events:
  - Target write on the tick cycle: the slew uses the old target; the new target applies from the next frame.
  - SNAP on the tick cycle: SNAP wins and the frame counter is unaffected. Only one pulse_vld is issued.
- Reset mid-frame: all state returns to reset values asynchronously; counting restarts at 0 after release.
- pulse_vld is never asserted on two consecutive cycles.

Optional Feature:
- Macro: SERVO_SLEW_IRQ_EN.
- Enabled: irq sets (level) on the cycle after both axes transition to settled following a frame in which either moved. Cleared by writing STATUS bit1 = 1; a clear and a set in the same cycle resolve to set.
- Disabled: irq tied to 0; STATUS bit1 writes ignored; no extra flops.

Decomposition:
- Package servo_slew_pkg holds:
  - register offsets (ADDR_XTGT=0, ADDR_YTGT=1, ADDR_STEP=2, ADDR_STAT=3);
  - STATUS bit indices;
  - the STEP width (16).
- Sub-module slew_axis, instantiated twice:
  - Inputs: tgt, step, tick, snap.
  - Outputs: cur, settled.
  - Holds the signed diff/clamp arithmetic.
- The top level holds APB decode, the frame counter, the strobe and irq.

Test Plan (bench uses PWM_PERIOD=100):
- Reset release -> x_pulse=y_pulse=150000, STEP reads 1000, STATUS reads 0x3, pulse_vld=0 until the first tick at cycle 99.
- Write X_TGT=155000 -> x_pulse becomes 151000, 152000 … 155000 on 5 successive pulse_vld strobes; STATUS bit0 is 0 until the 5th strobe.
- Write Y_TGT=250000 -> PSLVERR=1 in the access phase; Y_TGT reads 200000; Y_TGT=50000 reads back 100000.
- STEP=3000, X_TGT=151000 from 150000 -> one tick lands exactly on 151000 (no overshoot); STEP=0 with a pending target -> x_pulse is unchanged across 3 frames.
- Write X_TGT on the tick cycle (count 99) -> that frame's update uses the old target; STATUS SNAP write -> x_pulse=X_TGT on the next cycle, single pulse_vld.
- With SERVO_SLEW_IRQ_EN: a move to 152000 at STEP 1000 -> irq rises after the 2nd strobe; STATUS write 0x2 clears it. Without the macro: irq stays 0 throughout.
